// File: rtl/universal_shift_reg_n.sv
// WIDTH-bit universal shift register: hold/load/shift/rotate/arith-shift, serial taps.
// Optional multi-cycle burst rotate with busy/done, enabled by UNIVERSAL_SHIFT_REG_BURST_EN.
package usr_pkg;
  typedef enum logic [1:0] {OP_HOLD, OP_SHR, OP_SHL, OP_LOAD} cell_op_e;

  typedef struct packed {
    cell_op_e op;
    logic     hi_fill;
    logic     lo_fill;
  } slice_ctl_t;
endpackage

// One register bit: picks its next value from itself, a neighbour or the load bus.
module usr_cell
  import usr_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  cell_op_e op,
  input  logic     ld,
  input  logic     hi,
  input  logic     lo,
  output logic     q
);
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else begin
      case (op)
        OP_SHR:  q <= hi;
        OP_SHL:  q <= lo;
        OP_LOAD: q <= ld;
        default: q <= q;
      endcase
    end
  end
endmodule

module universal_shift_reg_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] data,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  output logic [WIDTH-1:0] salida,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);
  slice_ctl_t       ctl;
  logic             idle;
  logic [WIDTH-1:0] hi_vec, lo_vec;

  assign sout_r = salida[0];
  assign sout_l = salida[WIDTH-1];

  // Every right-moving op is a shift with a chosen MSB fill; likewise left with LSB fill.
  assign hi_vec = {ctl.hi_fill, salida[WIDTH-1:1]};
  assign lo_vec = {salida[WIDTH-2:0], ctl.lo_fill};

`ifdef UNIVERSAL_SHIFT_REG_BURST_EN
  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_e;

  state_e           state, state_nx;
  logic [AMT_W-1:0] cnt;
  logic             dir_q;
  logic             busy_nx, done_nx;
  logic             start;

  assign idle  = (state == S_IDLE);
  assign start = idle && en && (sel == 3'b111);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (amt == '0) ? S_DONE : S_BURST;
      S_BURST: if (cnt == AMT_W'(1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // busy/done come from the next state so they line up with the registered state.
  always_comb begin
    busy_nx = (state_nx != S_IDLE);
    done_nx = (state_nx == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
      if (start) begin
        cnt   <= amt;
        dir_q <= dir;
      end else if (state == S_BURST) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
`else
  logic unused_burst;

  assign idle         = 1'b1;
  assign busy         = 1'b0;
  assign done         = 1'b0;
  assign unused_burst = ^{amt, dir};
`endif

  always_comb begin
    ctl = '{OP_HOLD, 1'b0, 1'b0};
    if (idle && en) begin
      case (sel)
        3'b001:  ctl = '{OP_SHR, sin_r, 1'b0};
        3'b010:  ctl = '{OP_SHL, 1'b0, sin_l};
        3'b011:  ctl = '{OP_LOAD, 1'b0, 1'b0};
        3'b100:  ctl = '{OP_SHR, salida[0], 1'b0};
        3'b101:  ctl = '{OP_SHL, 1'b0, salida[WIDTH-1]};
        3'b110:  ctl = '{OP_SHR, salida[WIDTH-1], 1'b0};
        default: ctl = '{OP_HOLD, 1'b0, 1'b0};
      endcase
    end
`ifdef UNIVERSAL_SHIFT_REG_BURST_EN
    if (state == S_BURST)
      ctl = dir_q ? '{OP_SHL, 1'b0, salida[WIDTH-1]} : '{OP_SHR, salida[0], 1'b0};
`endif
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    usr_cell u_cell (
      .clk (clk),
      .rst (rst),
      .op  (ctl.op),
      .ld  (data[g]),
      .hi  (hi_vec[g]),
      .lo  (lo_vec[g]),
      .q   (salida[g])
    );
  end
endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Bench for universal_shift_reg_n: queue-based reference model checked every cycle,
// plus directed literal checks. Burst checks follow UNIVERSAL_SHIFT_REG_BURST_EN.
module tb_universal_shift_reg_n;
  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, en, sin_r, sin_l, dir;
  logic [2:0]    sel;
  logic [W-1:0]  data;
  logic [AW-1:0] amt;
  logic [W-1:0]  salida;
  logic          sout_r, sout_l, busy, done;

  int checks = 0;
  int errors = 0;

  universal_shift_reg_n #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .data(data), .sin_r(sin_r),
    .sin_l(sin_l), .amt(amt), .dir(dir), .salida(salida), .sout_r(sout_r),
    .sout_l(sout_l), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: register value plus a queue of pending burst work (1 = rotate, 0 = done cycle).
  logic [W-1:0] m;
  bit           m_dir;
  bit           pend[$];
  bit           mvalid = 0;

  function automatic logic [W-1:0] ror(input logic [W-1:0] v);
    return (v >> 1) | (v << (W-1));
  endfunction
  function automatic logic [W-1:0] rol(input logic [W-1:0] v);
    return (v << 1) | (v >> (W-1));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m = '0;
      pend.delete();
      mvalid = 1;
    end else if (pend.size() != 0) begin
      if (pend.pop_front()) m = m_dir ? rol(m) : ror(m);
    end else if (en) begin
      case (sel)
        3'd1: m = (m >> 1) | (W'(sin_r) << (W-1));
        3'd2: m = (m << 1) | W'(sin_l);
        3'd3: m = data;
        3'd4: m = ror(m);
        3'd5: m = rol(m);
        3'd6: m = W'($signed(m) >>> 1);
`ifdef UNIVERSAL_SHIFT_REG_BURST_EN
        3'd7: begin
          m_dir = dir;
          for (int i = 0; i < int'(amt); i++) pend.push_back(1'b1);
          pend.push_back(1'b0);
        end
`endif
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      logic exp_busy, exp_done;
      exp_busy = (pend.size() != 0);
      exp_done = exp_busy && (pend[0] == 1'b0);
      checks++;
      if (salida !== m || sout_r !== m[0] || sout_l !== m[W-1] ||
          busy !== exp_busy || done !== exp_done) begin
        errors++;
        $display("FAIL model t=%0t salida=%h sr=%b sl=%b busy=%b done=%b exp salida=%h busy=%b done=%b",
                 $time, salida, sout_r, sout_l, busy, done, m, exp_busy, exp_done);
      end
    end
  end

  task automatic lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [2:0] s, input logic [W-1:0] d,
                       input logic sr = 1'b0, input logic sl = 1'b0,
                       input logic [AW-1:0] a = '0, input logic dr = 1'b0);
    rst = r; en = e; sel = s; data = d; sin_r = sr; sin_l = sl; amt = a; dir = dr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 1, 3'b011, 8'hFF);
    tick(); tick();
    lit("reset_salida", salida, 8'h00);
    lit("reset_busy", W'(busy), 8'h00);
    lit("reset_done", W'(done), 8'h00);

    drive(0, 1, 3'b011, 8'hA5); tick(); lit("load_a5", salida, 8'hA5);
    drive(0, 1, 3'b001, 8'h00, 1); tick(); lit("shr_sin1", salida, 8'hD2);
    drive(0, 1, 3'b010, 8'h00, 0, 0); tick(); lit("shl_sin0", salida, 8'hA4);
    drive(0, 0, 3'b011, 8'h00); tick(); lit("en0_hold", salida, 8'hA4);

    drive(0, 1, 3'b011, 8'h81); tick();
    drive(0, 1, 3'b100, 8'h00); tick(); lit("ror_81", salida, 8'hC0);
    drive(0, 1, 3'b101, 8'h00); tick(); lit("rol_c0", salida, 8'h81);
    drive(0, 1, 3'b110, 8'h00); tick(); lit("asr_81", salida, 8'hC0);
    drive(0, 1, 3'b011, 8'h40); tick();
    drive(0, 1, 3'b110, 8'h00); tick(); lit("asr_40", salida, 8'h20);
    drive(0, 1, 3'b010, 8'h00, 0, 1); tick(); lit("shl_sin1", salida, 8'h41);
    lit("sout_l_0", W'(sout_l), 8'h00);
    lit("sout_r_1", W'(sout_r), 8'h01);
    drive(0, 1, 3'b000, 8'hFF); tick(); lit("hold", salida, 8'h41);

`ifdef UNIVERSAL_SHIFT_REG_BURST_EN
    begin
      int busy_cnt;
      logic [W-1:0] exp_seq [3];
      exp_seq = '{8'h02, 8'h04, 8'h08};
      drive(0, 1, 3'b011, 8'h01); tick();
      drive(0, 1, 3'b111, 8'h00, 0, 0, 3'd3, 1'b1); tick();
      lit("e0_unchanged", salida, 8'h01);
      lit("e0_busy", W'(busy), 8'h01);
      busy_cnt = 1;
      drive(0, 1, 3'b011, 8'hFF, 0, 0, 3'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        tick();
        lit($sformatf("burst_e%0d", i + 1), salida, exp_seq[i]);
        if (busy) busy_cnt++;
      end
      lit("burst_done", W'(done), 8'h01);
      tick();
      if (busy) busy_cnt++;
      lit("burst_busy_cycles", W'(busy_cnt), 8'd4);
      lit("burst_after", salida, 8'h08);
      lit("burst_done_clear", W'(done), 8'h00);

      drive(0, 1, 3'b111, 8'h00, 0, 0, 3'd0, 1'b1); tick();
      lit("amt0_done", W'(done), 8'h01);
      lit("amt0_salida", salida, 8'h08);
      drive(0, 0, 3'b000, 8'h00); tick();
      lit("amt0_busy_off", W'(busy), 8'h00);

      drive(0, 1, 3'b011, 8'h10); tick();
      drive(0, 1, 3'b111, 8'h00, 0, 0, 3'd7, 1'b0); tick();
      drive(0, 0, 3'b000, 8'h00);
      for (int i = 0; i < 20 && busy; i++) tick();
      lit("ror7_result", salida, 8'h20);
      lit("ror7_idle", W'(busy), 8'h00);

      drive(0, 1, 3'b011, 8'h0F); tick();
      drive(0, 1, 3'b111, 8'h00, 0, 0, 3'd5, 1'b0); tick();
      drive(0, 0, 3'b000, 8'h00); tick();
      lit("abort_e1", salida, 8'h87);
      drive(1, 0, 3'b000, 8'h00); tick();
      lit("abort_salida", salida, 8'h00);
      lit("abort_busy", W'(busy), 8'h00);
      lit("abort_done", W'(done), 8'h00);
      drive(0, 0, 3'b000, 8'h00);
      for (int i = 0; i < 6; i++) begin
        tick();
        lit("abort_no_done", W'(done | busy), 8'h00);
      end
    end
`else
    drive(0, 1, 3'b011, 8'h3C); tick();
    drive(0, 1, 3'b111, 8'h00, 0, 0, 3'd2, 1'b1); tick();
    lit("sel7_hold", salida, 8'h3C);
    lit("sel7_busy", W'(busy), 8'h00);
    lit("sel7_done", W'(done), 8'h00);
    tick();
    lit("sel7_hold2", salida, 8'h3C);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg_n.md
Name: universal_shift_reg_n

Overview:
- Parametrised successor to the 4-bit universal register: WIDTH-bit universal shift register.
- Supports hold, load, logical shifts with serial inputs, rotates and arithmetic shift right.
- Adds a synchronous reset, a clock enable and serial outputs.
- An optional multi-cycle burst-rotate mode reports progress through a busy/done handshake.
- General-purpose datapath element used wherever the designs need configurable shifting or serial/parallel conversion.

Parameters:
- WIDTH, 8, register width in bits (>= 2)
- AMT_W, 3, width of the burst rotate amount; ceil(log2(WIDTH)) is typical

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  clock enable; operations are accepted only when 1
- sel  input  3  operation select (see Behaviour)
- data  input  WIDTH  parallel load value
- sin_r  input  1  serial input shifted into the MSB on logical shift right
- sin_l  input  1  serial input shifted into the LSB on shift left
- amt  input  AMT_W  burst rotate amount
- dir  input  1  burst direction: 0 = right, 1 = left
- salida  output  WIDTH  register contents
- sout_r  output  1  always salida[0]
- sout_l  output  1  always salida[WIDTH-1]
- busy  output  1  burst in progress
- done  output  1  one-cycle burst-complete pulse

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- rst=1 at an edge: salida=0, state=IDLE, busy=0, done=0, internal count=0. Reset has priority over everything.
- Reset during a burst aborts the burst immediately; no done pulse is produced.
- All single-cycle operations take effect on the edge where en=1 and state=IDLE. Single-cycle latency; salida is registered.
- sel codes:
  - 000 hold.
  - 001 logical shift right: salida <= {sin_r, salida[WIDTH-1:1]}.
  - 010 shift left: salida <= {salida[WIDTH-2:0], sin_l}.
  - 011 load: salida <= data.
  - 100 rotate right.
  - 101 rotate left.
  - 110 arithmetic shift right: MSB replicated.
  - 111 burst rotate (only when BURST_EN is defined).
- en=0 in IDLE: salida holds regardless of sel.
- FSM states: IDLE, BURST, DONE.
  - IDLE with en=1 and sel=111 (acceptance edge E0): latch cnt=amt and dir; salida is unchanged at E0. Next state is DONE if amt==0, else BURST.
  - BURST: each edge rotates salida one position in the latched direction and decrements cnt. The edge where cnt goes 1->0 moves to DONE. Net effect: rotations at edges E1..Ek for amt=k.
  - DONE: done=1 for exactly this cycle. Next edge returns to IDLE with no change to salida.
  - busy=1 whenever state != IDLE. busy and done are registered decodes of state.
- While busy=1, en, sel, data, amt and dir are ignored; a new request is accepted only from IDLE.
- amt >= WIDTH is legal: the full amt rotations are performed, i.e. rotation by amt mod WIDTH.
- sout_r and sout_l are combinational taps of salida, so they reflect the current register value.

Optional Feature:
- Macro: UNIVERSAL_SHIFT_REG_BURST_EN.
- Defined: sel=111 performs the burst rotate, with the FSM, busy and done as above.
- Undefined:
  - sel=111 behaves as hold.
  - No FSM or counter logic is generated.
  - busy and done are tied to 0.
  - amt and dir are unused.

Test Plan:
- WIDTH=8. rst=1 for 2 cycles with data=8'hFF, sel=011 -> salida=8'h00, busy=0, done=0.
- Load, shift right, shift left:
  - load 8'hA5 -> salida=8'hA5.
  - sel=001 with sin_r=1 -> 8'hD2.
  - sel=010 with sin_l=0 -> 8'hA4.
  - en=0 with sel=011 and data=8'h00 -> salida stays 8'hA4.
- Load 8'h81:
  - rotate right -> 8'hC0.
  - rotate left -> 8'h81.
  - arithmetic shift right -> 8'hC0.
  - load 8'h40, then arithmetic shift right -> 8'h20.
- Burst (BURST_EN defined), load 8'h01:
  - sel=111, amt=3, dir=1 -> busy=1 for 4 cycles.
  - salida 8'h02, 8'h04, 8'h08 on E1..E3.
  - done=1 in the cycle after E3; salida=8'h08 thereafter.
  - sel changes during busy are ignored.
- Burst edge cases:
  - amt=0 -> done pulses in the cycle after E0, salida unchanged, busy=1 for exactly 1 cycle.
  - rst asserted mid-burst (after E1) -> next cycle salida=0, busy=0, no done pulse.
- BURST_EN undefined: sel=111 with salida=8'h3C, amt=2 -> salida stays 8'h3C, busy=0, done=0.
